// File: rtl/down_counter_timer.sv
// Down-counting timer with a reload register, one-shot and periodic modes.
// The timer has three states: IDLE, RUN and DONE.
// count and tc are registered outputs. busy decodes the registered state.
// The timer counts down to 0 and never wraps.
module down_counter_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] rld_r;
    logic [WIDTH-1:0] rld_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;

    // Saturating decrement: a zero input stays zero, so the counter never wraps to all-ones.
    function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] value);
        if (value == ZERO_C) begin
            dec_sat = ZERO_C;
        end else begin
            dec_sat = value - ONE_C;
        end
    endfunction

    // Next-state and next-output decode. Input priority is load, then stop, then start, then counting.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        rld_nxt_s   = rld_r;
        tc_nxt_s    = 1'b0;

        if (load) begin
            // A load updates both the reload value and the live count.
            // Loading zero parks the timer in IDLE.
            rld_nxt_s   = load_val;
            count_nxt_s = load_val;
            if (load_val == ZERO_C) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = state_r;
            end
        end else if (stop) begin
            // Stop halts a running count and keeps its value. It has no effect otherwise.
            if (state_r == ST_RUN) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (count_r != ZERO_C) begin
                            // Resume from the held count. The count does not change on this edge.
                            state_nxt_s = ST_RUN;
                        end else if (rld_r != ZERO_C) begin
                            // The count is exhausted, so restart from the reload value.
                            count_nxt_s = rld_r;
                            state_nxt_s = ST_RUN;
                        end else begin
                            // Nothing to count. Ignore the request.
                            state_nxt_s = state_r;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (count_r == ZERO_C) begin
                        // Periodic mode only: this is the reload cycle of the period.
                        count_nxt_s = rld_r;
                        state_nxt_s = ST_RUN;
                    end else if (count_r == ONE_C) begin
                        // Terminal edge. auto_reload is sampled only here.
                        count_nxt_s = ZERO_C;
                        tc_nxt_s    = 1'b1;
                        if (auto_reload) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_DONE;
                        end
                    end else begin
                        count_nxt_s = dec_sat(count_r);
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    // Recover from an unreachable encoding to a safe idle state.
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_C;
                end
            endcase
        end
    end

    // State, count, reload and tc registers with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
            count_r <= ZERO_C;
            rld_r   <= ZERO_C;
            tc_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            rld_r   <= rld_nxt_s;
            tc_r    <= tc_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign busy  = (state_r == ST_RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer.
// Directed scenarios run first, then randomized traffic.
// A behavioural reference model checks every cycle.
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk;
    logic         nrst;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Reference model state. It tracks plain integers and a running flag.
    int m_cnt = 0;
    int m_rld = 0;
    bit m_run = 1'b0;
    bit m_tc  = 1'b0;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .busy        (busy)
    );

    // Clock generator.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies the timer rules to the inputs sampled at the current edge.
    // IDLE and DONE react identically, so the model tracks only "running".
    task automatic model_step();
        m_tc = 1'b0;
        if (!nrst) begin
            m_cnt = 0;
            m_rld = 0;
            m_run = 1'b0;
        end else if (load) begin
            m_rld = int'(load_val);
            m_cnt = int'(load_val);
            if (load_val == 0) m_run = 1'b0;
        end else if (stop) begin
            m_run = 1'b0;
        end else if (start && !m_run) begin
            if (m_cnt != 0) begin
                m_run = 1'b1;
            end else if (m_rld != 0) begin
                m_cnt = m_rld;
                m_run = 1'b1;
            end
        end else if (m_run) begin
            if (m_cnt > 1) begin
                m_cnt = m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt = 0;
                m_tc  = 1'b1;
                if (!auto_reload) m_run = 1'b0;
            end else begin
                m_cnt = m_rld;
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model, and compares all outputs.
    task automatic cyc(input bit n, input bit l, input int v, input bit s, input bit p, input bit a);
        nrst        = n;
        load        = l;
        load_val    = v[W-1:0];
        start       = s;
        stop        = p;
        auto_reload = a;
        @(posedge clk);
        model_step();
        #1;
        check_val("count", 32'(count), 32'(m_cnt));
        check_val("tc", 32'(tc), 32'(m_tc));
        check_val("busy", 32'(busy), 32'(m_run));
    endtask

    task automatic idle(input bit a);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, a);
    endtask

    initial begin
        int per_c [9];
        int per_t [9];
        bit ar;
        nrst = 1'b0; load = 1'b0; load_val = '0;
        start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
        per_c = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
        per_t = '{0, 1, 0, 0, 1, 0, 0, 1, 0};

        // Reset state
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 9, 1'b1, 1'b0, 1'b1);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_tc", 32'(tc), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);

        // One-shot from 3
        cyc(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        check_val("os_load", 32'(count), 32'd3);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val("os_start_hold", 32'(count), 32'd3);
        check_val("os_busy", 32'(busy), 32'd1);
        idle(1'b0); check_val("os_c2", 32'(count), 32'd2);
        idle(1'b0); check_val("os_c1", 32'(count), 32'd1);
        idle(1'b0);
        check_val("os_c0", 32'(count), 32'd0);
        check_val("os_tc", 32'(tc), 32'd1);
        check_val("os_done_busy", 32'(busy), 32'd0);
        idle(1'b0);
        check_val("os_tc_once", 32'(tc), 32'd0);
        check_val("os_hold0", 32'(count), 32'd0);

        // Restart from DONE reloads the count
        cyc(1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check_val("rs_done", 32'(count), 32'd0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val("rs_reload", 32'(count), 32'd4);
        check_val("rs_busy", 32'(busy), 32'd1);
        idle(1'b0);
        check_val("rs_c3", 32'(count), 32'd3);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Periodic with reload value 2
        cyc(1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        check_val("per_start", 32'(count), 32'd2);
        for (int i = 0; i < 9; i++) begin
            idle(1'b1);
            check_val("per_count", 32'(count), 32'(per_c[i]));
            check_val("per_tc", 32'(tc), 32'(per_t[i]));
            check_val("per_busy", 32'(busy), 32'd1);
        end
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Stop and resume
        cyc(1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        check_val("sr_c5", 32'(count), 32'd5);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check_val("sr_stop_hold", 32'(count), 32'd5);
        check_val("sr_stop_busy", 32'(busy), 32'd0);
        idle(1'b0);
        check_val("sr_idle_hold", 32'(count), 32'd5);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(1'b0); check_val("sr_c4", 32'(count), 32'd4);
        idle(1'b0); check_val("sr_c3", 32'(count), 32'd3);

        // Start with rld=0 is ignored. Start and stop together give IDLE. Loading 0 while running gives IDLE.
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val("ec_start_rld0", 32'(busy), 32'd0);
        cyc(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        check_val("ec_startstop", 32'(busy), 32'd0);
        cyc(1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        check_val("ec_load0_cnt", 32'(count), 32'd0);
        check_val("ec_load0_busy", 32'(busy), 32'd0);

        // Reset mid-run, then a full count from all-ones
        cyc(1'b1, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);
        check_val("mr_c7", 32'(count), 32'd7);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check_val("mr_count", 32'(count), 32'd0);
        check_val("mr_tc", 32'(tc), 32'd0);
        check_val("mr_busy", 32'(busy), 32'd0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val("mr_rld_cleared", 32'(busy), 32'd0);
        cyc(1'b1, 1'b1, 15, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val("max_start", 32'(count), 32'd15);
        for (int i = 14; i >= 0; i--) begin
            idle(1'b0);
            check_val("max_count", 32'(count), 32'(i));
        end
        check_val("max_tc", 32'(tc), 32'd1);
        idle(1'b0);
        check_val("max_nowrap", 32'(count), 32'd0);

        // Randomized traffic
        ar = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) ar = ~ar;
            cyc($urandom_range(0, 63) != 0,
                $urandom_range(0, 9) == 0,
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15)),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 11) == 0,
                ar);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
